// File: rtl/general_defines.sv
// Shared core-wide constants and types: ROB entry layout, writeback record,
// widths, and the branch-mispredict predicate used at commit.
package general_defines;

    localparam int ROB_LENGTH      = 16;
    localparam int ROB_IDX_W       = $clog2(ROB_LENGTH);
    localparam int BYPASS_LENGTH   = 3;
    localparam int DISPATCH_W      = 2;
    localparam int COMMIT_W        = 2;
    localparam int INT_DATA_W      = 32;
    localparam int INSTR_MEM_IDX_W = 10;
    localparam int ARCH_REG_W      = 5;
    localparam int PHYS_REG_W      = 6;

    typedef struct packed {
        logic                       valid;
        logic                       done;
        logic [INSTR_MEM_IDX_W-1:0] pc;
        logic [ARCH_REG_W-1:0]      arch_rd;
        logic [PHYS_REG_W-1:0]      phys_rd;
        logic [PHYS_REG_W-1:0]      phys_rd_old;
        logic                       is_branch;
        logic                       pred_taken;
        logic [INSTR_MEM_IDX_W-1:0] pred_target;
        logic                       branch_taken;
        logic [INSTR_MEM_IDX_W-1:0] branch_target;
        logic [INT_DATA_W-1:0]      result;
    } rob_entry_t;

    typedef struct packed {
        logic                       valid;
        logic [ROB_IDX_W-1:0]       idx;
        logic [INT_DATA_W-1:0]      result;
        logic                       branch_taken;
        logic [INSTR_MEM_IDX_W-1:0] branch_target;
    } rob_wb_t;

    // A branch mispredicted if direction differs, or it was taken to a different target.
    function automatic logic is_mispredict(input rob_entry_t e);
        return e.is_branch &&
               ((e.pred_taken != e.branch_taken) ||
                (e.branch_taken && (e.pred_target != e.branch_target)));
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Picks which of the COMMIT_W oldest entries retire this cycle and whether
// one of them is a mispredicted branch that must redirect fetch.
module rob_commit_select
    import general_defines::rob_entry_t;
    import general_defines::is_mispredict;
    import general_defines::INSTR_MEM_IDX_W;
#(
    parameter int COMMIT_W = general_defines::COMMIT_W
) (
    input  rob_entry_t [COMMIT_W-1:0]    head_entry,
    output logic [COMMIT_W-1:0]          commit_valid,
    output logic                         flush_valid,
    output logic [INSTR_MEM_IDX_W-1:0]   flush_pc
);

    // In-order retire: stop at the first not-ready entry or just after a mispredict.
    always_comb begin
        logic run;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        commit_valid = '0;
        flush_valid  = 1'b0;
        flush_pc     = '0;
        // NOTE: 'run' is a combinational scratch variable, so blocking '=' is correct here.
        run          = 1'b1;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (run && head_entry[k].valid && head_entry[k].done) begin
                commit_valid[k] = 1'b1;
                if (is_mispredict(head_entry[k])) begin
                    flush_valid = 1'b1;
                    flush_pc    = head_entry[k].branch_taken ? head_entry[k].branch_target
                                                             : head_entry[k].pc + 1'b1;
                    run         = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// N-wide reorder buffer: multi-lane dispatch, multi-port writeback, in-order
// multi-commit with full flush on a retiring mispredicted branch.
module rob_multiport
    import general_defines::rob_entry_t;
    import general_defines::rob_wb_t;
    import general_defines::ROB_LENGTH;
    import general_defines::BYPASS_LENGTH;
    import general_defines::INT_DATA_W;
    import general_defines::INSTR_MEM_IDX_W;
#(
    parameter int DEPTH      = ROB_LENGTH,
    parameter int DISPATCH_W = general_defines::DISPATCH_W,
    parameter int COMMIT_W   = general_defines::COMMIT_W,
    parameter int WB_PORTS   = BYPASS_LENGTH,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [DISPATCH_W-1:0]                   disp_valid,
    input  rob_entry_t [DISPATCH_W-1:0]             disp_entry,
    output logic                                    disp_ready,
    output logic [DISPATCH_W-1:0][IDX_W-1:0]        disp_idx,
    input  logic [WB_PORTS-1:0]                     wb_valid,
    input  logic [WB_PORTS-1:0][IDX_W-1:0]          wb_idx,
    input  logic [WB_PORTS-1:0][INT_DATA_W-1:0]     wb_result,
    input  logic [WB_PORTS-1:0]                     wb_branch_taken,
    input  logic [WB_PORTS-1:0][INSTR_MEM_IDX_W-1:0] wb_branch_target,
    output logic [COMMIT_W-1:0]                     commit_valid,
    output rob_entry_t [COMMIT_W-1:0]               commit_entry,
    output logic                                    flush_valid,
    output logic [INSTR_MEM_IDX_W-1:0]              flush_pc,
    output logic [IDX_W:0]                          count,
    output logic                                    empty,
    output logic                                    full
);

    logic [IDX_W-1:0]                 head, tail;
    logic [DEPTH-1:0]                 ent_valid, ent_done;
    rob_entry_t                       ent_data [DEPTH];
    logic [COMMIT_W-1:0][IDX_W-1:0]   head_idx;
    rob_entry_t [COMMIT_W-1:0]        head_entry;
    rob_wb_t [WB_PORTS-1:0]           wb;
    logic [IDX_W:0]                   n_disp, n_commit;

    // Status and dispatch handshake; space is judged from registered count only.
    assign empty      = (count == '0);
    assign full       = (count == (IDX_W+1)'(DEPTH));
    assign disp_ready = ((DEPTH - int'(count)) >= DISPATCH_W) && !flush_valid;
    assign n_disp     = disp_ready ? (IDX_W+1)'($countones(disp_valid)) : '0;
    assign n_commit   = (IDX_W+1)'($countones(commit_valid));

    // Lane indices (wrap naturally) and the oldest entries presented to commit.
    always_comb begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            disp_idx[k] = tail + IDX_W'(k);
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            head_idx[k]        = head + IDX_W'(k);
            head_entry[k]      = ent_data[head_idx[k]];
            head_entry[k].valid = ent_valid[head_idx[k]];
            head_entry[k].done  = ent_done[head_idx[k]];
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            wb[p].valid         = wb_valid[p];
            wb[p].idx           = wb_idx[p];
            wb[p].result        = wb_result[p];
            wb[p].branch_taken  = wb_branch_taken[p];
            wb[p].branch_target = wb_branch_target[p];
        end
    end

    assign commit_entry = head_entry;

    rob_commit_select #(.COMMIT_W(COMMIT_W)) u_commit_select (
        .head_entry   (head_entry),
        .commit_valid (commit_valid),
        .flush_valid  (flush_valid),
        .flush_pc     (flush_pc)
    );

    // Pointers and occupancy; a flush empties the buffer behind the retiring branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head + n_commit[IDX_W-1:0];
            if (flush_valid) begin
                tail  <= head + n_commit[IDX_W-1:0];
                count <= '0;
            end else begin
                tail  <= tail + n_disp[IDX_W-1:0];
                count <= count + n_disp - n_commit;
            end
        end
    end

    // Per-entry valid/done: writeback marks done, commit clears, dispatch allocates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            ent_done  <= '0;
        end else if (flush_valid) begin
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb[p].valid && ent_valid[wb[p].idx]) ent_done[wb[p].idx] <= 1'b1;
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (commit_valid[k]) begin
                    ent_valid[head_idx[k]] <= 1'b0;
                    ent_done[head_idx[k]]  <= 1'b0;
                end
            end
            if (disp_ready) begin
                for (int k = 0; k < DISPATCH_W; k++) begin
                    if (disp_valid[k]) begin
                        ent_valid[disp_idx[k]] <= 1'b1;
                        ent_done[disp_idx[k]]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Entry payload: dispatch writes the whole record, writeback fills results;
    // later ports overwrite earlier ones so the highest port wins.
    // NOTE: the payload array has no reset; only valid/done need known state, and that lets it map to plain storage.
    always_ff @(posedge clk) begin
        if (!flush_valid) begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb[p].valid && ent_valid[wb[p].idx]) begin
                    ent_data[wb[p].idx].result        <= wb[p].result;
                    ent_data[wb[p].idx].branch_taken  <= wb[p].branch_taken;
                    ent_data[wb[p].idx].branch_target <= wb[p].branch_target;
                end
            end
            if (disp_ready) begin
                for (int k = 0; k < DISPATCH_W; k++) begin
                    if (disp_valid[k]) ent_data[disp_idx[k]] <= disp_entry[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: fill/full, ordered commit, wrap-around,
// mispredict flush, port priority and asynchronous reset.
module tb_rob_multiport;
    import general_defines::*;

    localparam int IW = ROB_IDX_W;

    logic clk, rst;
    logic [DISPATCH_W-1:0]                        disp_valid;
    rob_entry_t [DISPATCH_W-1:0]                  disp_entry;
    logic                                         disp_ready;
    logic [DISPATCH_W-1:0][IW-1:0]                disp_idx;
    logic [BYPASS_LENGTH-1:0]                     wb_valid;
    logic [BYPASS_LENGTH-1:0][IW-1:0]             wb_idx;
    logic [BYPASS_LENGTH-1:0][INT_DATA_W-1:0]     wb_result;
    logic [BYPASS_LENGTH-1:0]                     wb_branch_taken;
    logic [BYPASS_LENGTH-1:0][INSTR_MEM_IDX_W-1:0] wb_branch_target;
    logic [COMMIT_W-1:0]                          commit_valid;
    rob_entry_t [COMMIT_W-1:0]                    commit_entry;
    logic                                         flush_valid;
    logic [INSTR_MEM_IDX_W-1:0]                   flush_pc;
    logic [IW:0]                                  count;
    logic                                         empty, full;

    int n_checks = 0;
    int n_errors = 0;

    rob_multiport dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_entry(disp_entry),
        .disp_ready(disp_ready), .disp_idx(disp_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_result(wb_result),
        .wb_branch_taken(wb_branch_taken), .wb_branch_target(wb_branch_target),
        .commit_valid(commit_valid), .commit_entry(commit_entry),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .count(count), .empty(empty), .full(full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic rob_entry_t mk_alu(input int pc);
        rob_entry_t e;
        e         = '0;
        e.pc      = INSTR_MEM_IDX_W'(pc);
        e.arch_rd = ARCH_REG_W'(pc);
        return e;
    endfunction

    function automatic rob_entry_t mk_br(input int pc, input logic taken, input int target);
        rob_entry_t e;
        e             = '0;
        e.pc          = INSTR_MEM_IDX_W'(pc);
        e.is_branch   = 1'b1;
        e.pred_taken  = taken;
        e.pred_target = INSTR_MEM_IDX_W'(target);
        return e;
    endfunction

    task automatic clear_inputs();
        disp_valid       = '0;
        disp_entry       = '0;
        wb_valid         = '0;
        wb_idx           = '0;
        wb_result        = '0;
        wb_branch_taken  = '0;
        wb_branch_target = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic set_wb(input int p, input int idx, input int res, input logic taken, input int tgt);
        wb_valid[p]         = 1'b1;
        wb_idx[p]           = IW'(idx);
        wb_result[p]        = INT_DATA_W'(res);
        wb_branch_taken[p]  = taken;
        wb_branch_target[p] = INSTR_MEM_IDX_W'(tgt);
    endtask

    task automatic disp2(input rob_entry_t e0, input rob_entry_t e1);
        disp_valid    = 2'b11;
        disp_entry[0] = e0;
        disp_entry[1] = e1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #12;
        rst = 1'b0;

        // Reset state
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ready", disp_ready, 1);
        check("rst_commit", commit_valid, 0);
        check("rst_flush", flush_valid, 0);
        check("rst_idx1", disp_idx[1], 1);

        // Fill all 16 entries, two per cycle
        for (int i = 0; i < 8; i++) begin
            check("fill_idx0", disp_idx[0], 2 * i);
            check("fill_idx1", disp_idx[1], 2 * i + 1);
            disp2(mk_alu(2 * i), mk_alu(2 * i + 1));
            step();
        end
        check("full_count", count, 16);
        check("full_full", full, 1);
        check("full_ready", disp_ready, 0);
        check("full_commit", commit_valid, 0);

        // Writeback idx1 then idx0; dispatch while full must be ignored
        set_wb(0, 1, 'h11, 0, 0);
        disp2(mk_alu(99), mk_alu(98));
        step();
        check("full_ignore_disp", count, 16);
        check("wb1_no_commit", commit_valid, 2'b00);
        set_wb(0, 0, 'h10, 0, 0);
        check("wb0_no_bypass", commit_valid, 2'b00);
        step();
        check("pair_commit", commit_valid, 2'b11);
        check("pair_pc0", commit_entry[0].pc, 0);
        check("pair_pc1", commit_entry[1].pc, 1);
        check("pair_res1", commit_entry[1].result, 'h11);
        check("pair_full_ready", disp_ready, 0);
        step();
        check("pair_count", count, 14);
        check("pair_next_idle", commit_valid, 2'b00);

        // Wrap-around: allocate 0..13, retire all, then allocate 14,15,0,1
        do_reset();
        for (int i = 0; i < 7; i++) begin
            disp2(mk_alu(2 * i), mk_alu(2 * i + 1));
            step();
        end
        for (int c = 0; c < 5; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (3 * c + p < 14) set_wb(p, 3 * c + p, 3 * c + p, 0, 0);
            end
            step();
        end
        for (int i = 0; i < 20 && !empty; i++) step();
        check("drain_empty", empty, 1);
        check("wrap_idx0", disp_idx[0], 14);
        check("wrap_idx1", disp_idx[1], 15);
        disp2(mk_alu(214), mk_alu(215));
        step();
        check("wrap2_idx0", disp_idx[0], 0);
        check("wrap2_idx1", disp_idx[1], 1);
        disp2(mk_alu(200), mk_alu(201));
        step();
        check("wrap_count", count, 4);
        set_wb(0, 14, 'h14, 0, 0);
        step();
        check("wrap_c14", commit_valid, 2'b01);
        check("wrap_c14_pc", commit_entry[0].pc, 214);
        set_wb(1, 15, 'h15, 0, 0);
        set_wb(2, 0, 'h20, 0, 0);
        step();
        check("wrap_group", commit_valid, 2'b11);
        check("wrap_pc15", commit_entry[0].pc, 215);
        check("wrap_pc0", commit_entry[1].pc, 200);
        check("wrap_res0", commit_entry[1].result, 'h20);
        step();
        check("wrap_count_after", count, 1);

        // Mispredicted branch at idx 3 (predicted not-taken, actually taken to 0x40)
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp2(mk_alu(2 * i), (2 * i + 1 == 3) ? mk_br(3, 0, 'h10) : mk_alu(2 * i + 1));
            step();
        end
        set_wb(0, 0, 0, 0, 0);
        set_wb(1, 1, 1, 0, 0);
        set_wb(2, 2, 2, 0, 0);
        step();
        check("br_pre_commit01", commit_valid, 2'b11);
        step();
        check("br_pre_commit2", commit_valid, 2'b01);
        set_wb(0, 3, 0, 1, 'h40);
        set_wb(1, 4, 4, 0, 0);
        step();
        check("br_commit", commit_valid, 2'b01);
        check("br_commit_pc", commit_entry[0].pc, 3);
        check("br_flush", flush_valid, 1);
        check("br_flush_pc", flush_pc, 'h40);
        check("br_ready", disp_ready, 0);
        disp2(mk_alu(77), mk_alu(78));
        set_wb(2, 5, 5, 0, 0);
        step();
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_commit", commit_valid, 2'b00);
        check("flush_ready", disp_ready, 1);
        check("flush_tail", disp_idx[0], 4);

        // Correctly predicted taken branch retires without flush
        disp_valid    = 2'b01;
        disp_entry[0] = mk_br('h30, 1, 'h20);
        step();
        check("okbr_tail", disp_idx[0], 5);
        set_wb(1, 4, 0, 1, 'h20);
        step();
        check("okbr_commit", commit_valid, 2'b01);
        check("okbr_pc", commit_entry[0].pc, 'h30);
        check("okbr_noflush", flush_valid, 0);
        step();
        check("okbr_empty", empty, 1);

        // Same-index writeback on ports 0 and 2: port 2 wins; idx 9 unallocated
        disp_valid    = 2'b01;
        disp_entry[0] = mk_alu('h50);
        step();
        set_wb(0, 5, 'hAAAA, 0, 0);
        set_wb(2, 5, 'h5555, 0, 0);
        set_wb(1, 9, 'h111, 0, 0);
        step();
        check("prio_commit", commit_valid, 2'b01);
        check("prio_result", commit_entry[0].result, 'h5555);
        step();
        disp2(mk_alu(6), mk_alu(7));
        step();
        disp2(mk_alu(8), mk_alu(9));
        step();
        check("drop_count", count, 4);
        set_wb(0, 6, 6, 0, 0);
        set_wb(1, 7, 7, 0, 0);
        set_wb(2, 8, 8, 0, 0);
        step();
        check("drop_c67", commit_valid, 2'b11);
        step();
        check("drop_c8_only", commit_valid, 2'b01);
        check("drop_c8_pc", commit_entry[0].pc, 8);
        step();
        check("drop_idx9_pending", count, 1);
        check("drop_idx9_notdone", commit_valid, 2'b00);

        // Asynchronous reset mid-stream with count=7
        for (int i = 0; i < 3; i++) begin
            disp2(mk_alu(10 + 2 * i), mk_alu(11 + 2 * i));
            step();
        end
        check("pre_rst_count", count, 7);
        set_wb(0, 9, 9, 0, 0);
        step();
        check("pre_rst_commit", commit_valid, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_commit", commit_valid, 2'b00);
        check("arst_ready", disp_ready, 1);
        check("arst_empty", empty, 1);
        check("arst_tail", disp_idx[0], 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
